fifo_stream_reader: RTL and testbench

Read-side drain stage for the FIFO. It watches the FIFO empty flag, issues `fifo_read_enable` pulses to advance the read side, and captures the buffer-RAM read data, which returns one cycle after each read. It presents that data downstream on a valid/ready stream. A 2-entry output buffer with credit accounting sustains one word per clock under continuous `out_ready`, never overflows, and never reads an empty FIFO.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/stream_skid_buffer.sv | 64 ++++++
 rtl/fifo_stream_reader.sv | 58 +++++
 tb/tb_fifo_stream_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and state encoding for the FIFO read-side blocks
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } entries_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// rtl/stream_skid_buffer.sv - 2-entry output buffer driven by push/pop/flush
module stream_skid_buffer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [1:0]            o_entries
);

  entries_e              r_entries;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  // Head is never cleared on flush so out_data holds its last value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_entries <= EMPTY;
      r_head    <= '0;
      r_tail    <= '0;
    end else if (i_flush) begin
      r_entries <= EMPTY;
    end else begin
      case (r_entries)
        EMPTY: begin
          if (i_push) begin
            r_entries <= ONE;
            r_head    <= i_data;
          end
        end
        ONE: begin
          if (i_push && !i_pop) begin
            r_entries <= TWO;
            r_tail    <= i_data;
          end else if (i_push && i_pop) begin
            r_head <= i_data;
          end else if (i_pop) begin
            r_entries <= EMPTY;
          end
        end
        TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail <= i_data;
            else        r_entries <= ONE;
          end
        end
        default: r_entries <= EMPTY;
      endcase
    end
  end

  assign o_valid   = (r_entries != EMPTY);
  assign o_data    = r_head;
  assign o_entries = r_entries;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains the FIFO read side onto a valid/ready stream
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic       r_inflight;
  logic       r_discard;
  logic       w_pop;
  logic       w_push;
  logic [2:0] w_level;
  logic [2:0] w_limit;

  assign w_pop  = out_valid & out_ready;
  assign w_push = r_inflight & ~r_discard;

  // Held plus in-flight words, less the one leaving now, must stay below 2.
  assign w_level = {1'b0, occupancy} + {2'b00, r_inflight};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign fifo_read_enable = reset & ~fifo_empty & ~flush & (w_level < w_limit);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_inflight <= fifo_read_enable;
      r_discard  <= flush & r_inflight;
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .i_flush   (flush),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_data    (fifo_read_data),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_entries (occupancy)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - scoreboard bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic [DW-1:0] fifo_read_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  logic [DW-1:0] mem [0:4095];
  int            wr_cnt  = 0;
  int            rd_cnt  = 0;
  int            n_reads = 0;
  int            n_cmp   = 0;
  int            n_fail  = 0;
  logic          rd_req_n = 1'b0;
  logic          rd_last  = 1'b0;
  logic [DW-1:0] exp_q [$];

  assign fifo_empty = (wr_cnt == rd_cnt);

  fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .reset            (reset),
    .flush            (flush),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_read_data   (fifo_read_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .occupancy        (occupancy)
  );

  always #5 clock = ~clock;

  // FIFO model: RAM data returns one cycle after the sampled read request.
  always @(posedge clock) begin
    if (rd_req_n) begin
      fifo_read_data <= mem[rd_cnt[11:0]];
      rd_cnt         <= rd_cnt + 1;
      n_reads        <= n_reads + 1;
    end
    rd_last <= rd_req_n;
  end

  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clock);
      rd_req_n = fifo_read_enable;
      if (fifo_empty) begin
        n_cmp++;
        if (fifo_read_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL read_while_empty: fifo_read_enable=%b required 0", fifo_read_enable);
        end
      end
      if (reset && occupancy == 2'd2 && !flush) begin
        n_cmp++;
        if (rd_last && !(out_valid && out_ready)) begin
          n_fail++;
          $display("FAIL push_when_two: push with occupancy=2 and no pop");
        end
      end
      if (reset && out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra_word: got %h, none expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h required %h", out_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] d, input bit track);
    mem[wr_cnt[11:0]] = d;
    wr_cnt++;
    if (track) exp_q.push_back(d);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) load(8'h11 + DW'(i), 1'b1);
    repeat (3) tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h occ=%0d required 0/00/0", out_valid, out_data, occupancy);
    end
    n_cmp++;
    if (fifo_read_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_read_enable: got %b required 0", fifo_read_enable);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (fifo_read_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL release_read_enable: got %b required 1", fifo_read_enable);
    end
  endtask

  task automatic test_streaming();
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_latency1: out_valid=%b required 0", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 + DW'(i)) begin
        n_fail++;
        $display("FAIL stream_word%0d: valid=%b data=%h required 1/%h", i, out_valid, out_data, 8'h11 + DW'(i));
      end
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_end: valid=%b pending=%0d required 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int base;
    out_ready = 1'b0;
    tick();
    base = n_reads;
    for (int i = 0; i < 6; i++) load(8'h21 + DW'(i), 1'b1);
    repeat (6) tick();
    n_cmp++;
    if (n_reads - base != 2 || occupancy !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h21) begin
      n_fail++;
      $display("FAIL bp_stall: reads=%0d occ=%0d valid=%b data=%h required 2/2/1/21",
               n_reads - base, occupancy, out_valid, out_data);
    end
    repeat (3) tick();
    n_cmp++;
    if (out_data !== 8'h21 || n_reads - base != 2) begin
      n_fail++;
      $display("FAIL bp_stable: data=%h reads=%0d required 21/2", out_data, n_reads - base);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 30 && (exp_q.size() != 0 || out_valid); k++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || n_reads - base != 6) begin
      n_fail++;
      $display("FAIL bp_drain: pending=%0d valid=%b reads=%0d required 0/0/6", exp_q.size(), out_valid, n_reads - base);
    end
  endtask

  task automatic test_near_empty();
    int base;
    out_ready = 1'b0;
    tick();
    base = n_reads;
    load(8'h31, 1'b1);
    for (int i = 0; i < 12; i++) begin
      out_ready = i[0];
      tick();
    end
    n_cmp++;
    if (n_reads - base != 1 || exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL near_empty: reads=%0d pending=%0d valid=%b required 1/0/0", n_reads - base, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    tick();
    load(8'h41, 1'b0);
    load(8'h42, 1'b0);
    load(8'h43, 1'b1);
    tick();
    tick();
    n_cmp++;
    if (occupancy !== 2'd1 || rd_last !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_setup: occ=%0d inflight=%b required 1/1", occupancy, rd_last);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 8'h41) begin
      n_fail++;
      $display("FAIL flush_state: occ=%0d valid=%b data=%h required 0/0/41", occupancy, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_after: pending=%0d valid=%b required 0/0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0 && wr_cnt - rd_cnt < 8)
        load(DW'($urandom_range(0, 255)), 1'b1);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 60 && (exp_q.size() != 0 || out_valid); k++) tick();
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0 || !fifo_empty) begin
      n_fail++;
      $display("FAIL random_drain: pending=%0d valid=%b empty=%b required 0/0/1", exp_q.size(), out_valid, fifo_empty);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_near_empty();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
